key_conditioner: RTL and testbench

//  Conditions the raw push-button inputs before they reach the HDMI pattern/control logic.
//  Per key: 2-FF synchroniser, debounce filter, press/release one-shots and hold-to-repeat.

---
 rtl/key_conditioner.sv | 161 ++++++++++++++++
 tb/tb_key_conditioner.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key synchroniser, debounce filter,
// press/release one-shots and hold-to-repeat. Keys are fully independent.

// One key channel: sync -> debounce -> edge pulses -> repeat FSM.
module key_conditioner_lane #(
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int DB_CYCLES      = 1_000_000,
    parameter int REPEAT_EN      = 1,
    parameter int HOLD_CYCLES    = 25_000_000,
    parameter int RATE_CYCLES    = 5_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_pin,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat,
    output logic key_event
);
    localparam int DBW  = $clog2(DB_CYCLES);
    localparam int TMAX = (HOLD_CYCLES > RATE_CYCLES) ? HOLD_CYCLES : RATE_CYCLES;
    localparam int TW   = $clog2(TMAX);

    // pin level while the key is not pressed
    localparam logic           RELEASED  = (KEY_ACTIVE_LOW != 0);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [TW-1:0]  HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]  RATE_LAST = TW'(RATE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic [1:0]     sync_ff;
    logic           p;
    logic [DBW-1:0] db_cnt;
    logic           accept, level_nxt, press_nxt, release_nxt;
    logic [1:0]     state, state_nxt;
    logic [TW-1:0]  tmr, tmr_nxt;
    logic           rep_nxt;

    // two-flop synchroniser; resets to the released pin level so a held key
    // is seen as a fresh press once reset lifts
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) sync_ff <= {2{RELEASED}};
        else            sync_ff <= {sync_ff[0], key_pin};
    end

    assign p           = sync_ff[1] ^ RELEASED;   // 1 = pressed
    assign accept      = (p != key_level) && (db_cnt == DB_LAST);
    assign level_nxt   = accept ? p : key_level;
    assign press_nxt   = accept & p;
    assign release_nxt = accept & ~p;

    // debounce counter: counts consecutive cycles p disagrees with key_level
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)             db_cnt <= '0;
        else if (p == key_level || accept) db_cnt <= '0;
        else                        db_cnt <= db_cnt + 1'b1;
    end

    // repeat FSM next state; keyed off the next level so a release landing
    // on a terminal count suppresses that repeat pulse
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        rep_nxt   = 1'b0;
        if (REPEAT_EN == 0 || !level_nxt) begin
            state_nxt = ST_IDLE;
            tmr_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (press_nxt) begin
                        state_nxt = ST_HOLD;
                        tmr_nxt   = '0;
                    end
                end
                ST_HOLD: begin
                    if (tmr == HOLD_LAST) begin
                        state_nxt = ST_REPEAT;
                        tmr_nxt   = '0;
                        rep_nxt   = 1'b1;
                    end else begin
                        tmr_nxt = tmr + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (tmr == RATE_LAST) begin
                        tmr_nxt = '0;
                        rep_nxt = 1'b1;
                    end else begin
                        tmr_nxt = tmr + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    tmr_nxt   = '0;
                end
            endcase
        end
    end

    // registered outputs and FSM state, all updated on the same edge
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            tmr         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
            key_event   <= 1'b0;
        end else begin
            state       <= state_nxt;
            tmr         <= tmr_nxt;
            key_level   <= level_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            key_repeat  <= rep_nxt;
            key_event   <= press_nxt | rep_nxt;
        end
    end
endmodule

module key_conditioner #(
    parameter int N_KEYS         = 2,
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int DB_CYCLES      = 1_000_000,
    parameter int REPEAT_EN      = 1,
    parameter int HOLD_CYCLES    = 25_000_000,
    parameter int RATE_CYCLES    = 5_000_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat,
    output logic [N_KEYS-1:0] key_event
);
    // one independent channel per key bit
    key_conditioner_lane #(
        .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
        .DB_CYCLES      (DB_CYCLES),
        .REPEAT_EN      (REPEAT_EN),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .RATE_CYCLES    (RATE_CYCLES)
    ) u_lane [N_KEYS-1:0] (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_pin     (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat),
        .key_event   (key_event)
    );
endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: scenario table of press/hold patterns plus
// bounce and mid-repeat reset sequences. Expected pulses go into a
// scoreboard keyed by cycle; a negedge monitor pops and compares every cycle.
module tb_key_conditioner;
    localparam int NK = 2;

    logic          sys_clk;
    logic          sys_rst_n;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_level, key_press, key_release, key_repeat, key_event;

    key_conditioner #(
        .N_KEYS(NK), .KEY_ACTIVE_LOW(1), .DB_CYCLES(16), .REPEAT_EN(1),
        .HOLD_CYCLES(64), .RATE_CYCLES(16)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_repeat(key_repeat), .key_event(key_event)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct {
        int cyc;
        int key;
        int kind;   // 0 press, 1 release, 2 repeat
    } exp_t;

    typedef struct {
        logic [NK-1:0] mask;    // keys pressed together
        int            hold;    // cycles the pin stays pressed
        bit            accept;  // press expected to be accepted
        int            n_rep;   // expected repeat pulses while held
    } vec_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    logic [NK-1:0] exp_level = '0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, expv);
        end
    endtask

    task automatic push(input int c, input int k, input int kind);
        exp_t e;
        e.cyc = c; e.key = k; e.kind = kind;
        sb.push_back(e);
    endtask

    // per-cycle compare of every output against the scoreboard
    always @(negedge sys_clk) begin
        if (cyc > 0) begin
            if (!sys_rst_n) exp_level = '0;
            for (int k = 0; k < NK; k++) begin
                bit ep, er, et;
                ep = 0; er = 0; et = 0;
                for (int i = sb.size() - 1; i >= 0; i--) begin
                    if (sb[i].cyc == cyc && sb[i].key == k) begin
                        if (sb[i].kind == 0) ep = 1;
                        else if (sb[i].kind == 1) er = 1;
                        else et = 1;
                        sb.delete(i);
                    end
                end
                if (ep) exp_level[k] = 1'b1;
                if (er) exp_level[k] = 1'b0;
                chk($sformatf("level%0d", k),   int'(key_level[k]),   int'(exp_level[k]));
                chk($sformatf("press%0d", k),   int'(key_press[k]),   int'(ep));
                chk($sformatf("release%0d", k), int'(key_release[k]), int'(er));
                chk($sformatf("repeat%0d", k),  int'(key_repeat[k]),  int'(et));
                chk($sformatf("event%0d", k),   int'(key_event[k]),   int'(ep | et));
            end
        end
    end

    initial begin
        vec_t vecs[8];
        int   c, r;

        vecs[0] = '{2'b01,  30, 1'b1, 0};  // basic press/release, 18-cycle latency
        vecs[1] = '{2'b01,  15, 1'b0, 0};  // one cycle too short to accept
        vecs[2] = '{2'b01,  16, 1'b1, 0};  // minimum accepted press
        vecs[3] = '{2'b10, 200, 1'b1, 9};  // long hold: +64, then every 16
        vecs[4] = '{2'b01,  64, 1'b1, 0};  // release lands on first terminal count
        vecs[5] = '{2'b10,  65, 1'b1, 1};  // release one cycle after first repeat
        vecs[6] = '{2'b11,  80, 1'b1, 1};  // both keys; release on second terminal
        vecs[7] = '{2'b11, 100, 1'b1, 3};  // both keys, several repeats

        // reset with keys released
        sys_rst_n = 1'b0;
        key_in    = 2'b11;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_outputs", int'({key_level, key_press, key_release, key_repeat, key_event}), 0);
        sys_rst_n = 1'b1;
        repeat (100) @(posedge sys_clk);

        // table-driven press/hold scenarios
        for (int v = 0; v < 8; v++) begin
            @(posedge sys_clk); #1;
            c = cyc;
            key_in = ~vecs[v].mask;
            for (int k = 0; k < NK; k++) begin
                if (vecs[v].mask[k] && vecs[v].accept) begin
                    push(c + 18, k, 0);
                    for (int i = 0; i < vecs[v].n_rep; i++) push(c + 82 + 16 * i, k, 2);
                    push(c + vecs[v].hold + 18, k, 1);
                end
            end
            repeat (vecs[v].hold) @(posedge sys_clk); #1;
            key_in = 2'b11;
            repeat (40) @(posedge sys_clk);
        end

        // bounce on key 0: pressed bursts of 10 cycles never qualify
        for (int b = 0; b < 5; b++) begin
            @(posedge sys_clk); #1;
            key_in[0] = 1'b0;
            repeat (10) @(posedge sys_clk); #1;
            key_in[0] = 1'b1;
            repeat (2) @(posedge sys_clk);
        end
        repeat (40) @(posedge sys_clk);

        // reset while key 1 is auto-repeating
        @(posedge sys_clk); #1;
        c = cyc;
        key_in = 2'b01;
        push(c + 18, 1, 0);
        push(c + 82, 1, 2);
        push(c + 98, 1, 2);
        repeat (110) @(posedge sys_clk); #1;
        chk("sb_drained", sb.size(), 0);
        sys_rst_n = 1'b0;
        #1;
        chk("rst_async", int'({key_level, key_press, key_release, key_repeat, key_event}), 0);
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        r = cyc;
        push(r + 18, 1, 0);
        push(r + 82, 1, 2);
        push(r + 98, 1, 2);
        push(r + 114, 1, 2);
        push(r + 118, 1, 1);
        repeat (100) @(posedge sys_clk); #1;
        key_in = 2'b11;
        repeat (40) @(posedge sys_clk);

        @(negedge sys_clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
